// File: rtl/top_interface.sv
// Operand-capture front end: loads operand A, operand B and opcode from a strobed
// byte stream, and pulses o_valid once for each completed triplet.
//
// state | meaning
// ST_A  | waiting for the operand A byte
// ST_B  | waiting for the operand B byte
// ST_OP | waiting for the opcode byte; this capture completes the triplet
module top_interface #(
  parameter int NB_DATA = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NB_DATA-1:0] din,
  input  logic               wr,
  output logic [NB_DATA-1:0] o_a,
  output logic [NB_DATA-1:0] o_b,
  output logic [NB_DATA-1:0] o_op,
  output logic               o_valid
);

  typedef enum logic [1:0] {ST_A, ST_B, ST_OP} state_t;

  state_t             state_q, state_d;
  logic               wr_q;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_DATA-1:0] op_q, op_d;
  logic               valid_q, valid_d;
  logic               accept;

  // A level-held strobe yields exactly one accept, on its rising edge.
  assign accept = wr & ~wr_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = 1'b0;
    if (accept) begin
      case (state_q)
        ST_A: begin
          a_d     = din;
          state_d = ST_B;
        end
        ST_B: begin
          b_d     = din;
          state_d = ST_OP;
        end
        ST_OP: begin
          op_d    = din;
          valid_d = 1'b1;
          state_d = ST_A;
        end
        default: state_d = ST_A;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_A;
      wr_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  assign o_a     = a_q;
  assign o_b     = b_q;
  assign o_op    = op_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_top_interface.sv
// Directed bench for top_interface: reset, triplet capture, long strobes,
// mid-sequence reset and reset coinciding with a write strobe.
module tb_top_interface;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din   = 8'h00;
  logic       wr    = 1'b0;
  logic [7:0] o_a, o_b, o_op;
  logic       o_valid;

  int n_checks = 0;
  int n_fail   = 0;

  top_interface #(.NB_DATA(8)) dut (
    .clock  (clock),
    .reset  (reset),
    .din    (din),
    .wr     (wr),
    .o_a    (o_a),
    .o_b    (o_b),
    .o_op   (o_op),
    .o_valid(o_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic v);
    chk({tag, ".a"}, o_a, a);
    chk({tag, ".b"}, o_b, b);
    chk({tag, ".op"}, o_op, op);
    chk({tag, ".valid"}, {7'b0, o_valid}, {7'b0, v});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-cycle strobe; on return the capturing edge has passed.
  task automatic pulse(input logic [7:0] d);
    din = d;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // 1: reset, then a single A capture
    wr = 1'b0;
    tick();
    chk_all("t1_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    reset = 1'b0;
    pulse(8'h03);
    chk_all("t1_a", 8'h03, 8'h00, 8'h00, 1'b0);
    tick();

    // 2: full triplet from a fresh reset
    do_reset();
    chk_all("t2_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    pulse(8'h03); chk_all("t2_a", 8'h03, 8'h00, 8'h00, 1'b0); tick();
    pulse(8'h02); chk_all("t2_b", 8'h03, 8'h02, 8'h00, 1'b0); tick();
    pulse(8'h24); chk_all("t2_op", 8'h03, 8'h02, 8'h24, 1'b1); tick();
    chk_all("t2_idle", 8'h03, 8'h02, 8'h24, 1'b0);

    // 3: repeated triplet, opcode 0x24 -> 0x20
    pulse(8'h03); chk_all("t3_a", 8'h03, 8'h02, 8'h24, 1'b0); tick();
    pulse(8'h02); chk_all("t3_b", 8'h03, 8'h02, 8'h24, 1'b0); tick();
    pulse(8'h20); chk_all("t3_op", 8'h03, 8'h02, 8'h20, 1'b1); tick();
    chk_all("t3_idle", 8'h03, 8'h02, 8'h20, 1'b0);

    // 4: wr held 4 cycles -> one accept only; later bytes must not land
    din = 8'h11;
    wr  = 1'b1;
    tick();
    chk_all("t4_first", 8'h11, 8'h02, 8'h20, 1'b0);
    din = 8'h99;
    tick(); tick(); tick();
    chk_all("t4_held", 8'h11, 8'h02, 8'h20, 1'b0);
    wr = 1'b0;
    tick();
    chk_all("t4_drop", 8'h11, 8'h02, 8'h20, 1'b0);
    pulse(8'h12); chk_all("t4_b", 8'h11, 8'h12, 8'h20, 1'b0); tick();
    pulse(8'h21); chk_all("t4_op", 8'h11, 8'h12, 8'h21, 1'b1); tick();

    // 5: reset after A and B, next write lands in A
    pulse(8'h05); tick();
    pulse(8'h06); chk_all("t5_ab", 8'h05, 8'h06, 8'h21, 1'b0); tick();
    do_reset();
    chk_all("t5_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    pulse(8'h07); chk_all("t5_a", 8'h07, 8'h00, 8'h00, 1'b0); tick();
    chk_all("t5_idle", 8'h07, 8'h00, 8'h00, 1'b0);

    // 6: reset with wr high; wr still high after release is accepted once
    din   = 8'h44;
    wr    = 1'b1;
    reset = 1'b1;
    tick();
    chk_all("t6_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    reset = 1'b0;
    din   = 8'h45;
    tick();
    chk_all("t6_accept", 8'h45, 8'h00, 8'h00, 1'b0);
    din = 8'h46;
    tick();
    chk_all("t6_held", 8'h45, 8'h00, 8'h00, 1'b0);
    wr = 1'b0;
    tick();
    pulse(8'h47); chk_all("t6_b", 8'h45, 8'h47, 8'h00, 1'b0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/top_interface.md
Name:
top_interface

Overview:
Operand-capture front end for the ALU/debug datapath. It takes a byte stream on a single write strobe and loads three registers in a fixed order: operand A, operand B, then opcode. The opcode is a MIPS funct code, for example 0x20 ADD or 0x24 AND. The registered values drive the downstream ALU inputs, and a one-cycle valid pulse marks each completed triplet.

Parameters:
NB_DATA, 8, width of the data byte and of each captured register

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
din  input  NB_DATA  data byte, sampled when a write is accepted
wr  input  1  write strobe, level; a write is accepted on its rising edge
o_a  output  NB_DATA  registered operand A
o_b  output  NB_DATA  registered operand B
o_op  output  NB_DATA  registered opcode, passed through unchanged
o_valid  output  1  one-cycle pulse after a complete A/B/OP triplet is captured

Behaviour:
- Single clock domain; no combinational path from inputs to outputs.
- Synchronous active-high reset (sampled on the clock edge):
  - o_a, o_b, o_op = 0; o_valid = 0.
  - Internal wr_d = 0; FSM = ST_A.
- Write-accept detection:
  - wr_d is a register copy of wr, updated every cycle.
  - A write is accepted in a cycle where wr=1 and wr_d=0.
  - Holding wr high for N>1 cycles gives exactly one accept.
  - wr must return low for at least one cycle before the next accept.
- FSM states and transitions (one transition per accepted write):
  - ST_A: on accept, o_a <= din, go to ST_B.
  - ST_B: on accept, o_b <= din, go to ST_OP.
  - ST_OP: on accept, o_op <= din, o_valid <= 1, go to ST_A.
  - No accept: stay in the current state; all data registers hold.
- Latency: the captured byte is visible on its output immediately after the clock edge that samples the accepting wr=1 cycle.
- o_valid:
  - High for exactly the one cycle following the OP capture, then 0.
  - It is never asserted for an A or B capture.
- Outputs hold their last captured values indefinitely. A new triplet overwrites registers one at a time, so o_a changes before o_b and o_op are updated.
- No decoding or validity check of din; any byte is legal in any slot.
- Reset mid-sequence (e.g. in ST_B or ST_OP):
  - Clears all registers and returns the FSM to ST_A.
  - A partially written triplet is discarded.
- Reset and wr high in the same cycle: reset wins and no capture occurs. wr_d is cleared, so if wr is still high after reset, the first post-reset cycle with wr=1 is accepted.
- The sequence wraps from ST_OP to ST_A indefinitely; there is no overflow condition.

Test Plan:
1. Reset: hold reset=1 for 1 cycle -> o_a=o_b=o_op=0, o_valid=0. Then a one-cycle wr pulse with din=0x03 -> o_a=0x03 one edge later; o_b and o_op stay 0.
2. Full triplet: one-cycle wr pulses, one idle cycle apart, din=0x03, 0x02, 0x24 -> o_a=0x03, o_b=0x02, o_op=0x24; o_valid=1 for exactly the one cycle after the third capture.
3. Repeated triplets: continue with 0x03, 0x02, 0x20 -> o_op switches 0x24->0x20. o_a/o_b are rewritten with identical values. o_valid pulses once per triplet.
4. Long strobe: hold wr=1 for 4 cycles with din=0x11, then drop it -> only o_a=0x11 is captured. The FSM is in ST_B and o_b is unchanged.
5. Reset mid-operation: capture A=0x05 and B=0x06, assert reset, then write 0x07 -> all outputs 0 after reset; 0x07 lands in o_a, not o_op; no o_valid.
6. Reset with wr=1 in the same cycle -> no capture; a wr that stays high after reset release is accepted once on the first post-reset cycle.
